// File: rtl/io_sample_capture_if.sv
// io_sample_capture_if
//   IO bus between the soft CPU (master) and an IO slave such as the sample
//   capture peripheral (slave).
//   io_addr_strobe   address strobe, qualifier only
//   io_read_strobe   one-cycle read request
//   io_write_strobe  one-cycle write request
//   io_addr          byte address
//   io_write_data    write data
//   io_read_data     read data, non-zero only while io_ready=1
//   io_ready         one-cycle completion pulse from the addressed slave
interface io_sample_capture_if;
  logic        io_addr_strobe;
  logic        io_read_strobe;
  logic        io_write_strobe;
  logic [31:0] io_addr;
  logic [31:0] io_write_data;
  logic [31:0] io_read_data;
  logic        io_ready;

  modport master (
    output io_addr_strobe, io_read_strobe, io_write_strobe, io_addr, io_write_data,
    input  io_read_data, io_ready
  );

  modport slave (
    input  io_addr_strobe, io_read_strobe, io_write_strobe, io_addr, io_write_data,
    output io_read_data, io_ready
  );
endinterface

// File: rtl/io_sample_capture.sv
// io_sample_capture
//   Logic-analyzer capture peripheral on the soft CPU IO bus. The 16 probe
//   lines are synchronised, sampled every DIV+1 clocks while running and
//   pushed into a FIFO that the CPU drains through the DATA register.
//
//   Optional build macro IO_SAMPLE_CAPTURE_TRIGGER_EN adds the TRIG register
//   at offset 0x10 (32-byte window) and the ARMED state that waits for a
//   masked pattern match before capture starts.
//
// Ports
//   clk_48     48 MHz system clock
//   rst        asynchronous active-high reset
//   bus        IO bus slave port (strobes, address, data, io_ready)
//   sample_in  asynchronous probe lines
//
// Registers (offset from ADDR_BASE)
//   0x0 CTRL   bit0 enable, bit1 clear (self-clearing)
//   0x4 DIV    bits15:0
//   0x8 STATUS count, bit16 overflow, bit17 empty, bit18 full, bits21:20 state
//   0xC DATA   bit31 valid, bits15:0 oldest sample (read pops)
module io_sample_capture #(
  parameter logic [31:0] ADDR_BASE       = 32'hC000_0000,
  parameter int          FIFO_DEPTH_LOG2 = 5
) (
  input  logic               clk_48,
  input  logic               rst,
  io_sample_capture_if.slave bus,
  input  logic [15:0]        sample_in
);
  localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;
`ifdef IO_SAMPLE_CAPTURE_TRIGGER_EN
  localparam int WIN_LSB = 5;
`else
  localparam int WIN_LSB = 4;
`endif
  localparam logic [WIN_LSB-1:0] OFS_CTRL   = WIN_LSB'(4'h0);
  localparam logic [WIN_LSB-1:0] OFS_DIV    = WIN_LSB'(4'h4);
  localparam logic [WIN_LSB-1:0] OFS_STATUS = WIN_LSB'(4'h8);
  localparam logic [WIN_LSB-1:0] OFS_DATA   = WIN_LSB'(4'hC);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_RUN   = 2'b10
  } state_t;

  logic                       hit, rd_hit, wr_hit;
  logic [WIN_LSB-1:0]         ofs;
  logic                       wr_ctrl, wr_div, clear;
  logic [15:0]                sync_p0, sync_p1;
  state_t                     state_q, state_d;
  logic                       enter_run;
  logic                       enable_q;
  logic [15:0]                div_q, div_cnt;
  logic                       sample_stb;
  logic [15:0]                mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]              count;
  logic                       empty, full, overflow_q;
  logic                       pop, push;
  logic [31:0]                rdata_d, rdata_p1;
  logic                       ack_p1;
  logic                       unused_bits;

  assign hit    = bus.io_addr[31:WIN_LSB] == ADDR_BASE[31:WIN_LSB];
  assign ofs    = bus.io_addr[WIN_LSB-1:0];
  assign rd_hit = bus.io_read_strobe & hit;
  assign wr_hit = bus.io_write_strobe & hit;

  assign wr_ctrl = wr_hit && (ofs == OFS_CTRL);
  assign wr_div  = wr_hit && (ofs == OFS_DIV);
  assign clear   = wr_ctrl & bus.io_write_data[1];

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Pop happens on the strobe cycle; the read mux returns the pre-pop head.
  assign pop        = rd_hit && (ofs == OFS_DATA) && !empty;
  // A sample strobe in the clear cycle is discarded.
  assign sample_stb = (state_q == ST_RUN) && (div_cnt == 16'd0) && !clear;
  // When full, a simultaneous pop frees the slot so the push still succeeds.
  assign push       = sample_stb && (!full || pop);

`ifdef IO_SAMPLE_CAPTURE_TRIGGER_EN
  localparam logic [WIN_LSB-1:0] OFS_TRIG = WIN_LSB'(5'h10);
  logic [31:0] trig_q;
  logic        wr_trig, trig_match;

  assign wr_trig    = wr_hit && (ofs == OFS_TRIG);
  assign trig_match = ((sync_p1 ^ trig_q[31:16]) & trig_q[15:0]) == 16'h0;
  assign unused_bits = bus.io_addr_strobe;

  always_ff @(posedge clk_48 or posedge rst) begin
    if (rst) begin
      trig_q <= '0;
    end else if (wr_trig) begin
      trig_q <= bus.io_write_data;
    end
  end
`else
  assign unused_bits = ^{bus.io_addr_strobe, bus.io_write_data[31:16]};
`endif

  // Probe synchroniser: capture stage p0, sample stage p1
  always_ff @(posedge clk_48 or posedge rst) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= sample_in;
      sync_p1 <= sync_p0;
    end
  end

  // Capture FSM
  always_ff @(posedge clk_48 or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
`ifdef IO_SAMPLE_CAPTURE_TRIGGER_EN
    if (state_q == ST_ARMED && trig_match) begin
      state_d = ST_RUN;
    end
`endif
    // A CTRL write overrides the trigger: disable always wins.
    if (wr_ctrl) begin
      if (!bus.io_write_data[0]) begin
        state_d = ST_IDLE;
      end else if (state_q == ST_IDLE) begin
`ifdef IO_SAMPLE_CAPTURE_TRIGGER_EN
        state_d = ST_ARMED;
`else
        state_d = ST_RUN;
`endif
      end
    end
  end

  assign enter_run = (state_d == ST_RUN) && (state_q != ST_RUN);

  // Control registers and sample-rate divider
  always_ff @(posedge clk_48 or posedge rst) begin
    if (rst) begin
      enable_q <= 1'b0;
      div_q    <= '0;
      div_cnt  <= '0;
    end else begin
      if (wr_ctrl) begin
        enable_q <= bus.io_write_data[0];
      end
      if (wr_div) begin
        div_q <= bus.io_write_data[15:0];
      end
      // The counter always reloads from the pre-write DIV, so a DIV write
      // while running only changes the period from the next reload on.
      if (clear || enter_run) begin
        div_cnt <= div_q;
      end else if (state_q == ST_RUN) begin
        div_cnt <= (div_cnt == 16'd0) ? div_q : div_cnt - 16'd1;
      end
    end
  end

  // Sample FIFO
  always_ff @(posedge clk_48) begin
    if (push) begin
      mem[wr_ptr] <= sync_p1;
    end
  end

  always_ff @(posedge clk_48 or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (sample_stb && !push) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Read mux, evaluated on the strobe cycle
  always_comb begin
    rdata_d = '0;
    if (rd_hit) begin
      case (ofs)
        OFS_CTRL:   rdata_d[0] = enable_q;
        OFS_DIV:    rdata_d[15:0] = div_q;
        OFS_STATUS: begin
          rdata_d[CW-1:0] = count;
          rdata_d[16]     = overflow_q;
          rdata_d[17]     = empty;
          rdata_d[18]     = full;
          rdata_d[21:20]  = state_q;
        end
        OFS_DATA: begin
          if (!empty) begin
            rdata_d = {16'h8000, mem[rd_ptr]};
          end
        end
`ifdef IO_SAMPLE_CAPTURE_TRIGGER_EN
        OFS_TRIG:   rdata_d = trig_q;
`endif
        default: ;
      endcase
    end
  end

  // Bus response stage p1: acknowledge one cycle after the strobe
  always_ff @(posedge clk_48 or posedge rst) begin
    if (rst) begin
      ack_p1   <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      ack_p1   <= rd_hit | wr_hit;
      rdata_p1 <= rdata_d;
    end
  end

  assign bus.io_ready     = ack_p1;
  assign bus.io_read_data = rdata_p1;
endmodule

// File: tb/tb_io_sample_capture.sv
// tb_io_sample_capture
//   Self-checking bench for io_sample_capture. A queue-based reference model
//   tracks the capture rules cycle by cycle; directed scenarios and a random
//   phase compare every bus response against it.
module tb_io_sample_capture;
`ifdef IO_SAMPLE_CAPTURE_TRIGGER_EN
  localparam bit TRIG_EN = 1'b1;
`else
  localparam bit TRIG_EN = 1'b0;
`endif
  localparam int          WIN   = TRIG_EN ? 5 : 4;
  localparam int          DEPTH = 32;
  localparam logic [31:0] BASE  = 32'hC000_0000;

  logic        clk_48 = 1'b0;
  logic        rst;
  logic [15:0] sample_in;
  int          n_chk = 0;
  int          n_err = 0;

  io_sample_capture_if bus ();

  io_sample_capture #(
    .ADDR_BASE       (BASE),
    .FIFO_DEPTH_LOG2 (5)
  ) dut (
    .clk_48    (clk_48),
    .rst       (rst),
    .bus       (bus),
    .sample_in (sample_in)
  );

  always #10 clk_48 = ~clk_48;

  // Reference model
  logic [15:0] m_q [$];
  logic [15:0] m_s1, m_s2, m_div, m_cnt;
  logic [31:0] m_trig, m_rdata;
  logic        m_en, m_ovf, m_ready;
  int          m_state;

  always @(posedge clk_48 or posedge rst) begin : model
    logic        hit, rs, ws, clr, stb, load;
    logic [31:0] a, wd, rdv;
    int          off, nxt;
    if (rst) begin
      m_q.delete();
      m_s1 = '0; m_s2 = '0; m_div = '0; m_cnt = '0;
      m_trig = '0; m_rdata = '0;
      m_en = 1'b0; m_ovf = 1'b0; m_ready = 1'b0;
      m_state = 0;
    end else begin
      a   = bus.io_addr;
      wd  = bus.io_write_data;
      rs  = bus.io_read_strobe;
      ws  = bus.io_write_strobe;
      hit = (rs || ws) && ((a >> WIN) == (BASE >> WIN));
      off = int'(a & ((32'd1 << WIN) - 32'd1));
      rdv = '0;
      if (rs && hit) begin
        if (off == 0) rdv = {31'b0, m_en};
        else if (off == 4) rdv = {16'b0, m_div};
        else if (off == 8) begin
          rdv        = 32'(m_q.size());
          rdv[16]    = m_ovf;
          rdv[17]    = (m_q.size() == 0);
          rdv[18]    = (m_q.size() == DEPTH);
          rdv[21:20] = 2'(m_state);
        end
        else if (off == 12 && m_q.size() != 0) rdv = {16'h8000, m_q[0]};
        else if (TRIG_EN && off == 16) rdv = m_trig;
      end
      stb = (m_state == 2) && (m_cnt == 16'd0);
      clr = ws && hit && off == 0 && wd[1];
      if (clr) begin
        m_q.delete();
        m_ovf = 1'b0;
      end else begin
        if (rs && hit && off == 12 && m_q.size() != 0) void'(m_q.pop_front());
        if (stb) begin
          if (m_q.size() < DEPTH) m_q.push_back(m_s2);
          else m_ovf = 1'b1;
        end
      end
      nxt  = m_state;
      load = 1'b0;
      if (m_state == 1 && ((m_s2 & m_trig[15:0]) == (m_trig[31:16] & m_trig[15:0]))) begin
        nxt  = 2;
        load = 1'b1;
      end
      if (ws && hit && off == 0) begin
        m_en = wd[0];
        if (!wd[0]) nxt = 0;
        else if (m_state == 0) begin
          nxt  = TRIG_EN ? 1 : 2;
          load = !TRIG_EN;
        end
      end
      if (clr || load) m_cnt = m_div;
      else if (m_state == 2) m_cnt = (m_cnt == 16'd0) ? m_div : m_cnt - 16'd1;
      if (ws && hit && off == 4) m_div = wd[15:0];
      if (TRIG_EN && ws && hit && off == 16) m_trig = wd;
      m_s2    = m_s1;
      m_s1    = sample_in;
      m_rdata = rdv;
      m_ready = hit;
      m_state = nxt;
    end
  end

  task automatic idle;
    @(posedge clk_48); #1;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic rdy);
    bus.io_addr        = addr;
    bus.io_addr_strobe = 1'b1;
    bus.io_read_strobe = 1'b1;
    @(posedge clk_48); #1;
    bus.io_addr_strobe = 1'b0;
    bus.io_read_strobe = 1'b0;
    data = bus.io_read_data;
    rdy  = bus.io_ready;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] wdata, output logic rdy);
    bus.io_addr         = addr;
    bus.io_write_data   = wdata;
    bus.io_addr_strobe  = 1'b1;
    bus.io_write_strobe = 1'b1;
    @(posedge clk_48); #1;
    bus.io_addr_strobe  = 1'b0;
    bus.io_write_strobe = 1'b0;
    rdy = bus.io_ready;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    logic        r;
    rst = 1'b1;
    bus.io_addr = BASE + 32'h8;
    bus.io_read_strobe = 1'b1;
    repeat (3) idle();
    bus.io_read_strobe = 1'b0;
    n_chk++;
    if (bus.io_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %0b want 0", bus.io_ready); end
    n_chk++;
    if (bus.io_read_data !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", bus.io_read_data); end
    rst = 1'b0;
    idle();
    bus_read(BASE + 32'h8, d, r);
    n_chk++;
    if (r !== 1'b1) begin n_err++; $display("FAIL reset_status_ready: got %0b want 1", r); end
    n_chk++;
    if (d !== 32'h0002_0000) begin n_err++; $display("FAIL reset_status: got %h want 00020000", d); end
  endtask

  task automatic test_capture_div3;
    logic [31:0] d;
    logic        r;
    sample_in = 16'hA5A5;
    bus_write(BASE + 32'h4, 32'd3, r);
    bus_write(BASE + 32'h0, 32'd1, r);
    repeat (16) idle();
    bus_write(BASE + 32'h0, 32'd0, r);
    bus_read(BASE + 32'h8, d, r);
    n_chk++;
    if (d[5:0] !== 6'd4 || d !== m_rdata) begin
      n_err++; $display("FAIL div3_count: got %h want count 4 (model %h)", d, m_rdata);
    end
    for (int i = 0; i < 5; i++) begin
      bus_read(BASE + 32'hC, d, r);
      n_chk++;
      if (r !== 1'b1 || d !== ((i < 4) ? 32'h8000_A5A5 : 32'h0) || d !== m_rdata) begin
        n_err++; $display("FAIL div3_data%0d: got rdy=%0b %h want %h", i, r, d, (i < 4) ? 32'h8000_A5A5 : 32'h0);
      end
    end
  endtask

  task automatic test_overflow_clear;
    logic [31:0] d;
    logic        r;
    bus_write(BASE + 32'h0, 32'd2, r);
    bus_write(BASE + 32'h4, 32'd0, r);
    bus_write(BASE + 32'h0, 32'd1, r);
    repeat (40) idle();
    bus_write(BASE + 32'h0, 32'd0, r);
    bus_read(BASE + 32'h8, d, r);
    n_chk++;
    if (d !== 32'h0005_0020 || d !== m_rdata) begin
      n_err++; $display("FAIL ovf_status: got %h want 00050020", d);
    end
    bus_write(BASE + 32'h0, 32'd2, r);
    n_chk++;
    if (r !== 1'b1) begin n_err++; $display("FAIL clear_ack: got %0b want 1", r); end
    bus_read(BASE + 32'h8, d, r);
    n_chk++;
    if (d !== 32'h0002_0000) begin n_err++; $display("FAIL clear_status: got %h want 00020000", d); end
  endtask

  task automatic test_full_pop;
    logic [31:0] d;
    logic        r;
    bus_write(BASE + 32'h0, 32'd3, r);
    repeat (32) idle();
    for (int i = 0; i < 10; i++) begin
      bus_read(BASE + 32'hC, d, r);
      n_chk++;
      if (r !== 1'b1 || d !== 32'h8000_A5A5 || d !== m_rdata) begin
        n_err++; $display("FAIL fullpop_data%0d: got rdy=%0b %h want 8000a5a5", i, r, d);
      end
    end
    bus_read(BASE + 32'h8, d, r);
    n_chk++;
    if (d[5:0] !== 6'd32 || d[16] !== 1'b0 || d[18] !== 1'b1 || d !== m_rdata) begin
      n_err++; $display("FAIL fullpop_status: got %h want 00240020", d);
    end
    bus_write(BASE + 32'h0, 32'd0, r);
  endtask

  task automatic test_window;
    logic [31:0] d;
    logic        r;
    bus_write(BASE + 32'h100, 32'd1, r);
    n_chk++;
    if (r !== 1'b0) begin n_err++; $display("FAIL oow_write_ready: got %0b want 0", r); end
    bus_read(BASE + 32'h108, d, r);
    n_chk++;
    if (r !== 1'b0 || d !== 32'h0) begin n_err++; $display("FAIL oow_read: got rdy=%0b %h want 0", r, d); end
    bus_read(BASE + 32'h8, d, r);
    n_chk++;
    if (d[21:20] !== 2'b00 || d !== m_rdata) begin
      n_err++; $display("FAIL oow_state: got %h want %h", d, m_rdata);
    end
    bus_write(BASE + 32'h4, 32'hDEAD_BEEF, r);
    bus_read(BASE + 32'h4, d, r);
    n_chk++;
    if (d !== 32'h0000_BEEF) begin n_err++; $display("FAIL div_readback: got %h want 0000beef", d); end
    bus_write(BASE + 32'h8, 32'hFFFF_FFFF, r);
    n_chk++;
    if (r !== 1'b1) begin n_err++; $display("FAIL ro_write_ack: got %0b want 1", r); end
    bus_write(BASE + 32'h4, 32'd0, r);
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    logic        r;
    bus_write(BASE + 32'h0, 32'd1, r);
    repeat (5) idle();
    bus.io_addr = BASE + 32'h8;
    bus.io_read_strobe = 1'b1;
    @(posedge clk_48); #1;
    bus.io_read_strobe = 1'b0;
    n_chk++;
    if (bus.io_ready !== 1'b1) begin n_err++; $display("FAIL mid_pre_ready: got %0b want 1", bus.io_ready); end
    rst = 1'b1;
    #1;
    n_chk++;
    if (bus.io_ready !== 1'b0 || bus.io_read_data !== 32'h0) begin
      n_err++; $display("FAIL mid_reset_cancel: got rdy=%0b %h want 0", bus.io_ready, bus.io_read_data);
    end
    idle();
    rst = 1'b0;
    idle();
    bus_read(BASE + 32'h8, d, r);
    n_chk++;
    if (d !== 32'h0002_0000) begin n_err++; $display("FAIL mid_reset_status: got %h want 00020000", d); end
  endtask

`ifdef IO_SAMPLE_CAPTURE_TRIGGER_EN
  task automatic test_trigger;
    logic [31:0] d;
    logic        r;
    sample_in = 16'h0000;
    bus_write(BASE + 32'h10, 32'h0042_00FF, r);
    bus_write(BASE + 32'h0, 32'd1, r);
    repeat (20) idle();
    bus_read(BASE + 32'h8, d, r);
    n_chk++;
    if (d !== 32'h0012_0000) begin n_err++; $display("FAIL trig_armed: got %h want 00120000", d); end
    sample_in = 16'h1342;
    repeat (6) idle();
    bus_read(BASE + 32'h8, d, r);
    n_chk++;
    if (d[21:20] !== 2'b10 || d[5:0] == 6'd0 || d !== m_rdata) begin
      n_err++; $display("FAIL trig_run: got %h want %h", d, m_rdata);
    end
    bus_write(BASE + 32'h0, 32'd2, r);
  endtask
`endif

  task automatic test_random;
    logic [31:0] d, a;
    logic        r;
    int          op;
    int          offs [5] = '{0, 4, 8, 12, 2};
    for (int i = 0; i < 400; i++) begin
      sample_in = 16'($urandom);
      op = $urandom_range(0, 9);
      case (op)
        0, 1: begin
          idle();
          n_chk++;
          if (bus.io_ready !== m_ready || bus.io_read_data !== m_rdata) begin
            n_err++; $display("FAIL rnd_idle%0d: got rdy=%0b %h want rdy=%0b %h", i, bus.io_ready, bus.io_read_data, m_ready, m_rdata);
          end
        end
        5, 6: begin
          a = BASE + ((op == 5) ? 32'h0 : 32'h4);
          d = (op == 5) ? {30'b0, ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0)}
                        : (($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 3)));
          bus_write(a, d, r);
          n_chk++;
          if (r !== 1'b1 || bus.io_read_data !== m_rdata) begin
            n_err++; $display("FAIL rnd_write%0d: got rdy=%0b %h want 1 %h", i, r, bus.io_read_data, m_rdata);
          end
        end
        7: begin
          a = ($urandom_range(0, 1) == 1) ? BASE + 32'h100 : 32'h4000_000C;
          if ($urandom_range(0, 1) == 1) bus_read(a, d, r);
          else bus_write(a, 32'h3, r);
          n_chk++;
          if (r !== 1'b0) begin n_err++; $display("FAIL rnd_oow%0d: got rdy=%0b want 0", i, r); end
        end
        default: begin
          a = BASE + 32'((op >= 8) ? 12 : offs[$urandom_range(0, 4)]);
          bus_read(a, d, r);
          n_chk++;
          if (r !== 1'b1 || d !== m_rdata) begin
            n_err++; $display("FAIL rnd_read%0d @%h: got rdy=%0b %h want 1 %h", i, a, r, d, m_rdata);
          end
        end
      endcase
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst                 = 1'b1;
    sample_in           = '0;
    bus.io_addr_strobe  = 1'b0;
    bus.io_read_strobe  = 1'b0;
    bus.io_write_strobe = 1'b0;
    bus.io_addr         = '0;
    bus.io_write_data   = '0;
    #1;
    test_reset();
    test_capture_div3();
    test_overflow_clear();
    test_full_pop();
    test_window();
    test_reset_mid();
`ifdef IO_SAMPLE_CAPTURE_TRIGGER_EN
    test_trigger();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
